// File: rtl/uart_trans.sv
// -----------------------------------------------------------------------------
// uart_trans -- framed serial transmitter
//
// A frame is: SIG (announce) | START | PACKET_SIZE data bits MSB first |
// [PARITY] | STOP. Each element lasts CYCLE_DIV clk cycles.
// On an accepted request the block latches the data word. It then drives the
// announce line and the bitstream toward a matching receiver. It pulses done
// on the final clk of the stop bit.
//
// Optional feature macro: UART_TRANS_PARITY_EN
//   When it is defined, an even-parity bit (XOR of the data bits) follows the
//   data bits. When it is undefined, no parity state or logic exists.
//
// Parameters
//   PACKET_SIZE : data bits per frame (1..16)
//   CYCLE_DIV   : clk cycles per serial bit period (2..65535)
//
// Ports
//   clk     in   single clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   send    in   transmit request, ignored while busy
//   data    in   word to transmit, sampled only when a request is accepted
//   sendSig out  transmit-announce line (registered)
//   bsOut   out  serial bitstream, idle high (registered)
//   busy    out  high whenever the FSM is not IDLE
//   done    out  one-clk pulse on the last clk of the stop bit
// -----------------------------------------------------------------------------
module uart_trans #(
  parameter int unsigned PACKET_SIZE = 4,
  parameter int unsigned CYCLE_DIV   = 100
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   send,
  input  logic [PACKET_SIZE-1:0] data,
  output logic                   sendSig,
  output logic                   bsOut,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned DIV_W = $clog2(CYCLE_DIV);
  localparam int unsigned CNT_W = $clog2(PACKET_SIZE + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CYCLE_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PACKET_SIZE);

  typedef enum logic [2:0] {
    IDLE,
    SIG,
    START,
    DATA,
`ifdef UART_TRANS_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                 r_state,   w_state;
  logic [DIV_W-1:0]       r_div,     w_div;
  logic [CNT_W-1:0]       r_cnt,     w_cnt;
  logic [PACKET_SIZE-1:0] r_shift,   w_shift;
  logic                   r_sendSig, w_sendSig;
  logic                   r_bsOut,   w_bsOut;
`ifdef UART_TRANS_PARITY_EN
  logic                   r_par,     w_par;
`endif

  logic w_bit_end;

  // Last clk of the current bit period.
  assign w_bit_end = (r_div == DIV_LAST);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_div     <= '0;
      r_cnt     <= '0;
      r_shift   <= '0;
      r_sendSig <= 1'b0;
      r_bsOut   <= 1'b1;
`ifdef UART_TRANS_PARITY_EN
      r_par     <= 1'b0;
`endif
    end else begin
      r_state   <= w_state;
      r_div     <= w_div;
      r_cnt     <= w_cnt;
      r_shift   <= w_shift;
      r_sendSig <= w_sendSig;
      r_bsOut   <= w_bsOut;
`ifdef UART_TRANS_PARITY_EN
      r_par     <= w_par;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. The line outputs are computed one clk ahead so that they
  // come straight from flops and change together with the state.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state   = r_state;
    w_div     = r_div;
    w_cnt     = r_cnt;
    w_shift   = r_shift;
    w_sendSig = r_sendSig;
    w_bsOut   = r_bsOut;
`ifdef UART_TRANS_PARITY_EN
    w_par     = r_par;
`endif

    // Bit-period divider runs in every state except IDLE.
    if (r_state != IDLE) begin
      w_div = w_bit_end ? '0 : r_div + 1'b1;
    end

    unique case (r_state)
      IDLE: begin
        if (send) begin
          w_state   = SIG;
          w_shift   = data;
          w_cnt     = '0;
          w_div     = '0;
          w_sendSig = 1'b1;
          w_bsOut   = 1'b1;
`ifdef UART_TRANS_PARITY_EN
          w_par     = ^data;
`endif
        end
      end

      SIG: begin
        if (w_bit_end) begin
          w_state   = START;
          w_sendSig = 1'b0;
          w_bsOut   = 1'b0;
        end
      end

      START: begin
        // The first data bit goes out on this boundary, so r_cnt counts
        // bits already placed on the line.
        if (w_bit_end) begin
          w_state = DATA;
          w_bsOut = r_shift[PACKET_SIZE-1];
          w_shift = r_shift << 1;
          w_cnt   = CNT_W'(1);
        end
      end

      DATA: begin
        if (w_bit_end) begin
          if (r_cnt == CNT_LAST) begin
`ifdef UART_TRANS_PARITY_EN
            w_state = PARITY;
            w_bsOut = r_par;
`else
            w_state = STOP;
            w_bsOut = 1'b1;
`endif
          end else begin
            w_bsOut = r_shift[PACKET_SIZE-1];
            w_shift = r_shift << 1;
            w_cnt   = r_cnt + 1'b1;
          end
        end
      end

`ifdef UART_TRANS_PARITY_EN
      PARITY: begin
        if (w_bit_end) begin
          w_state = STOP;
          w_bsOut = 1'b1;
        end
      end
`endif

      STOP: begin
        if (w_bit_end) begin
          w_state   = IDLE;
          w_bsOut   = 1'b1;
          w_sendSig = 1'b0;
        end
      end

      default: begin
        w_state   = IDLE;
        w_div     = '0;
        w_cnt     = '0;
        w_sendSig = 1'b0;
        w_bsOut   = 1'b1;
      end
    endcase
  end

  assign sendSig = r_sendSig;
  assign bsOut   = r_bsOut;
  assign busy    = (r_state != IDLE);
  // The pulse comes from register state only. It covers the final clk of
  // STOP, the clk that ends with the return edge to IDLE.
  assign done    = (r_state == STOP) && w_bit_end;

endmodule

// File: tb/tb_uart_trans.sv
// -----------------------------------------------------------------------------
// tb_uart_trans -- self-checking bench for uart_trans.
// The expected line levels of a frame are written as a list of bit-period
// values (announce, start, data MSB first, optional parity, stop). The DUT is
// sampled on every falling clk edge against that list.
// -----------------------------------------------------------------------------
module tb_uart_trans;

  localparam int unsigned P   = 4;
  localparam int unsigned DIV = 100;
`ifdef UART_TRANS_PARITY_EN
  localparam int unsigned NB  = P + 4;
`else
  localparam int unsigned NB  = P + 3;
`endif
  localparam int unsigned L   = NB * DIV;

  logic         clk;
  logic         rst_n;
  logic         send;
  logic [P-1:0] data;
  logic         sendSig;
  logic         bsOut;
  logic         busy;
  logic         done;

  int unsigned n_pass = 0;
  int unsigned n_tot  = 0;

  uart_trans #(
    .PACKET_SIZE (P),
    .CYCLE_DIV   (DIV)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .send    (send),
    .data    (data),
    .sendSig (sendSig),
    .bsOut   (bsOut),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string nm, input string detail);
    n_tot++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", nm, detail);
  endtask

  function automatic string sig_name(input int k);
    case (k)
      0:       return "done";
      1:       return "busy";
      2:       return "sendSig";
      default: return "bsOut";
    endcase
  endfunction

  // Starts a frame and checks every clk from the accepting edge through one
  // clk past the frame. exp_lv holds the expected bsOut level per bit period,
  // with the first period in the MSB.
  task automatic run_frame(input string nm, input logic [P-1:0] d,
                           input logic [NB-1:0] exp_lv, input bit mid,
                           input bit scramble, input bit hold);
    logic [3:0]  act;
    logic [3:0]  expv;
    int unsigned bad [4];
    int unsigned fn  [4];
    logic        fg  [4];
    logic        fw  [4];
    for (int k = 0; k < 4; k++) begin
      bad[k] = 0; fn[k] = 0; fg[k] = 1'b0; fw[k] = 1'b0;
    end
    @(negedge clk);
    send = 1'b1;
    data = d;
    @(posedge clk);
    for (int unsigned n = 1; n <= L + 1; n++) begin
      @(negedge clk);
      act = {bsOut, sendSig, busy, done};
      if (n <= L)
        expv = {exp_lv[NB-1-((n-1)/DIV)], (n <= DIV), 1'b1, (n == L)};
      else
        expv = 4'b1000;
      for (int k = 0; k < 4; k++) begin
        if (act[k] !== expv[k]) begin
          if (bad[k] == 0) begin
            fn[k] = n; fg[k] = act[k]; fw[k] = expv[k];
          end
          bad[k]++;
        end
      end
      if (!hold) send = 1'b0;
      if (mid && n == 300) begin
        send = 1'b1;
        data = 4'b0011;
      end else if (scramble) begin
        data = P'($urandom);
      end
    end
    for (int k = 0; k < 4; k++)
      chk(bad[k] == 0, $sformatf("%s %s", nm, sig_name(k)),
          $sformatf("clk %0d got %0b want %0b (%0d bad clks)", fn[k], fg[k], fw[k], bad[k]));
  endtask

  typedef struct {
    string        nm;
    logic [P-1:0] d;
    logic [P-1:0] bits;
    logic         par;
    bit           mid;
    bit           scr;
  } vec_t;

  initial begin
    vec_t          tv [7];
    logic [NB-1:0] lvl;
    logic [P-1:0]  d;
    int unsigned   cnt;
    bit            seen;
    bit            bad_seen;

    tv[0] = '{"basic_1100",   4'b1100, 4'b1100, 1'b0, 1'b0, 1'b0};
    tv[1] = '{"midsend_1100", 4'b1100, 4'b1100, 1'b0, 1'b1, 1'b0};
    tv[2] = '{"par_1101",     4'b1101, 4'b1101, 1'b1, 1'b0, 1'b1};
    tv[3] = '{"par_1001",     4'b1001, 4'b1001, 1'b0, 1'b0, 1'b0};
    tv[4] = '{"loop_0110",    4'b0110, 4'b0110, 1'b0, 1'b0, 1'b1};
    tv[5] = '{"zeros",        4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};
    tv[6] = '{"ones",         4'b1111, 4'b1111, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0;
    send  = 1'b0;
    data  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk(bsOut === 1'b1 && sendSig === 1'b0 && busy === 1'b0 && done === 1'b0, "reset_state",
        $sformatf("bsOut/sendSig/busy/done got %b%b%b%b want 1000", bsOut, sendSig, busy, done));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven frames.
    for (int i = 0; i < 7; i++) begin
      lvl = {1'b1, 1'b0, tv[i].bits,
`ifdef UART_TRANS_PARITY_EN
             tv[i].par,
`endif
             1'b1};
      run_frame(tv[i].nm, tv[i].d, lvl, tv[i].mid, tv[i].scr, 1'b0);
      repeat (2) @(negedge clk);
    end

    // Reset in the middle of a frame, between clk edges.
    @(negedge clk);
    send = 1'b1;
    data = 4'b1011;
    @(posedge clk);
    @(negedge clk);
    send = 1'b0;
    repeat (349) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk(bsOut === 1'b1 && sendSig === 1'b0 && busy === 1'b0 && done === 1'b0, "async_reset",
        $sformatf("bsOut/sendSig/busy/done got %b%b%b%b want 1000", bsOut, sendSig, busy, done));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad_seen = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) bad_seen = 1'b1;
    end
    chk(!bad_seen, "aborted_frame_quiet", $sformatf("done/busy activity got %0b want 0", bad_seen));
    lvl = {1'b1, 1'b0, 4'b0110,
`ifdef UART_TRANS_PARITY_EN
           1'b0,
`endif
           1'b1};
    run_frame("post_reset", 4'b0110, lvl, 1'b0, 1'b0, 1'b0);

    // send held high: back-to-back frames with one idle clk in between.
    lvl = {1'b1, 1'b0, 4'b1010,
`ifdef UART_TRANS_PARITY_EN
           1'b0,
`endif
           1'b1};
    run_frame("b2b_first", 4'b1010, lvl, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk(sendSig === 1'b1 && busy === 1'b1, "b2b_restart",
        $sformatf("sendSig/busy got %b%b want 11", sendSig, busy));
    send = 1'b0;
    seen = 1'b0;
    cnt  = 0;
    while (!seen && cnt < L + 20) begin
      @(negedge clk);
      cnt++;
      if (done === 1'b1) seen = 1'b1;
    end
    chk(seen && cnt == L - 1, "b2b_second_done",
        $sformatf("done after %0d clks (seen=%0b) want %0d", cnt, seen, L - 1));
    @(negedge clk);
    chk(busy === 1'b0, "b2b_idle_after", $sformatf("busy got %b want 0", busy));

    // Randomized frames against the period-list model.
    for (int i = 0; i < 8; i++) begin
      d = P'($urandom);
      lvl = {1'b1, 1'b0, d,
`ifdef UART_TRANS_PARITY_EN
             ^d,
`endif
             1'b1};
      run_frame($sformatf("rand%0d_%b", i, d), d, lvl, 1'b0, 1'b1, 1'b0);
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/uart_trans.md
UART_TRANS -- requirements
Module: uart_trans

Interface
REQ-001 Parameter PACKET_SIZE, default 4, SHALL set the data bits per frame (legal range 1..16).
REQ-002 Parameter CYCLE_DIV, default 100, SHALL set clk cycles per serial bit period (sclk = clk/CYCLE_DIV; legal 2..65535).
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 Port send  input  1  SHALL request transmission of data; sampled on every rising edge.
REQ-006 Port data  input  PACKET_SIZE  SHALL be the word to transmit, sampled only when a request is accepted.
REQ-007 Port sendSig  output  1  SHALL be the transmit-announce line toward the receiver's recSig input.
REQ-008 Port bsOut  output  1  SHALL be the serial bitstream toward the receiver's bsIn input; idle high.
REQ-009 Port busy  output  1  SHALL be high whenever the state machine is not IDLE.
REQ-010 Port done  output  1  SHALL be a one-clk pulse marking frame completion.

Function
REQ-011 FSM states SHALL be IDLE, SIG, START, DATA, (PARITY), STOP; every state except IDLE SHALL last exactly CYCLE_DIV clk per bit.
REQ-012 In IDLE with send=1 at a rising edge, the block SHALL latch data into a shift register, clear the bit counter and divider, and enter SIG on that edge.
REQ-013 send SHALL be ignored while busy=1; there SHALL be no queueing.
REQ-014 SIG: sendSig=1, bsOut=1 for CYCLE_DIV clk, then START.
REQ-015 START: sendSig=0, bsOut=0 for CYCLE_DIV clk, then DATA.
REQ-016 DATA: bsOut SHALL present latched data MSB first, one bit per CYCLE_DIV clk, PACKET_SIZE bits, then PARITY (if enabled) else STOP.
REQ-017 STOP: bsOut=1 for CYCLE_DIV clk; on the last STOP cycle edge, done SHALL pulse for exactly one clk and the FSM SHALL return to IDLE.
REQ-018 Divider SHALL count 0..CYCLE_DIV-1 and wrap to 0 at each bit boundary; bit counter width SHALL be ceil(log2(PACKET_SIZE+1)).
REQ-019 Frame length SHALL be (3+PACKET_SIZE) bit periods without parity, (4+PACKET_SIZE) with; for defaults, 700 clk.
REQ-020 send held high continuously SHALL start a new frame on the first edge after IDLE is re-entered (one idle clk between frames).
REQ-021 bsOut and sendSig SHALL be driven from registers (glitch-free).
REQ-022 Changing data while busy SHALL not affect the frame in progress.

Reset
REQ-023 rst_n=0 SHALL immediately, without waiting for clk, force IDLE, sendSig=0, bsOut=1, busy=0, done=0, divider=0, bit counter=0.
REQ-024 Reset asserted mid-frame SHALL abort the frame; no done pulse SHALL be produced for it.
REQ-025 After rst_n deasserts, the first accepted send SHALL produce a complete, correct frame.

Configuration
REQ-026 Macro UART_TRANS_PARITY_EN, when defined, SHALL add state PARITY after DATA, driving bsOut to the even-parity bit (XOR of the data bits) for CYCLE_DIV clk.
REQ-027 Without UART_TRANS_PARITY_EN, no PARITY state or logic SHALL exist and DATA SHALL go directly to STOP.

Verification
REQ-028 Defaults, data=4'b1100, one-clk send pulse at t0 -> sendSig high clk 1..100, bsOut 0 clk 101..200, then 1,1,0,0 per 100 clk, stop high 601..700, done pulse at clk 700, busy low after.
REQ-029 send pulsed again at clk 300 mid-frame with data=4'b0011 -> ignored; bitstream still 1100; a single done pulse.
REQ-030 rst_n driven low at clk 350 between clk edges -> bsOut=1, sendSig=0, busy=0 immediately; no done; a new send then yields a full 700-clk frame.
REQ-031 send held high, data=4'b1010 -> back-to-back frames, exactly one idle clk between done and next sendSig rise.
REQ-032 UART_TRANS_PARITY_EN defined, data=4'b1101 -> parity bit 1 at clk 601..700, stop 701..800, done at 800; data=4'b1001 -> parity 0.
REQ-033 Loopback to the existing receiver (sendSig->recSig, bsOut->bsIn, matching PACKET_SIZE/CYCLE_DIV), data=4'b0110 -> receiver data output equals 4'b0110.
